// File: rtl/half_adder_cell.sv
// Single-lane half adder: two 1-bit addends in, sum and carry out.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum and carry for one lane.
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule

// File: rtl/half_adder.sv
// Bit-parallel half adder with an optional output register stage and a
// valid qualifier, so it can sit directly inside a pipelined datapath.
module half_adder #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  // Independent lanes; there is no carry path between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (X[i]),
      .b (Y[i]),
      .s (sum_w[i]),
      .c (carry_w[i])
    );
  end

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             valid_q, valid_d;

    // Capture a new result only when qualified; otherwise hold the last one.
    always_comb begin
      s_d     = s_q;
      c_d     = c_q;
      valid_d = in_valid;
      if (in_valid) begin
        s_d = sum_w;
        c_d = carry_w;
      end
    end

    // Output register; reset clears any result in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q     <= '0;
        c_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        s_q     <= s_d;
        c_q     <= c_d;
        valid_q <= valid_d;
      end
    end

    assign S         = s_q;
    assign C         = c_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no role in the combinational variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign S         = sum_w;
    assign C         = carry_w;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: registered 4-lane and 1-lane instances
// share clock/reset, plus a combinational 1-lane instance.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] x4, y4;
  logic [3:0] s4, c4;
  logic       v4;
  logic [0:0] s1, c1;
  logic       v1;

  logic       xc, yc, vc;
  logic [0:0] sc, cc;
  logic       vco;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state for the registered instances.
  logic [3:0] exp_s, exp_c;
  logic       exp_v;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(4), .REGISTERED(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X(x4), .Y(y4),
    .S(s4), .C(c4), .out_valid(v4)
  );

  half_adder #(.WIDTH(1), .REGISTERED(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X(x4[0:0]), .Y(y4[0:0]),
    .S(s1), .C(c1), .out_valid(v1)
  );

  half_adder #(.WIDTH(1), .REGISTERED(0)) dutc (
    .clk(clk), .rst(rst), .in_valid(vc), .X(xc), .Y(yc),
    .S(sc), .C(cc), .out_valid(vco)
  );

  // Per-lane arithmetic: {carry,sum} is the 2-bit value a+b.
  function automatic logic [7:0] add_lanes(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s, c;
    for (int i = 0; i < 4; i++) begin
      int t;
      t    = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    return {c, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      $error("%s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reg(input string tag);
    chk({tag, ".S4"}, 32'(s4), 32'(exp_s));
    chk({tag, ".C4"}, 32'(c4), 32'(exp_c));
    chk({tag, ".V4"}, 32'(v4), 32'(exp_v));
    chk({tag, ".S1"}, 32'(s1), 32'(exp_s[0]));
    chk({tag, ".C1"}, 32'(c1), 32'(exp_c[0]));
    chk({tag, ".V1"}, 32'(v1), 32'(exp_v));
  endtask

  // Drive one cycle of input from the falling edge, check after the rising edge.
  task automatic step(input string tag, input logic [3:0] x, input logic [3:0] y, input logic v);
    logic [7:0] r;
    x4 = x; y4 = y; in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      r     = add_lanes(x, y);
      exp_s = r[3:0];
      exp_c = r[7:4];
    end
    exp_v = v;
    check_reg(tag);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rx, ry;
    logic [3:0] tx, ty;
    rst = 1'b1; in_valid = 1'b1; x4 = 4'hF; y4 = 4'hF;
    xc = 1'b0; yc = 1'b0; vc = 1'b0;
    exp_s = '0; exp_c = '0; exp_v = 1'b0;

    // Reset asserted from time 0 holds outputs low across a valid edge.
    #2;
    check_reg("rst_async");
    @(negedge clk);
    check_reg("rst_hold");
    rst = 1'b0;

    // Truth table on lane 0, other lanes random.
    tx = 4'b0011; ty = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      rx = 4'($urandom); ry = 4'($urandom);
      rx[0] = tx[i]; ry[0] = ty[i];
      step($sformatf("tt%0d", i), rx, ry, 1'b1);
    end

    // Hold: 11 captured, then invalid 01 must not disturb it.
    step("hold_load", 4'b0001, 4'b0001, 1'b1);
    chk("hold_load.C", 32'(c1), 32'd1);
    step("hold_keep", 4'b0000, 4'b0001, 1'b0);
    chk("hold_keep.C", 32'(c1), 32'd1);
    chk("hold_keep.S", 32'(s1), 32'd0);

    // Inputs moving between edges leave registered outputs alone.
    x4 = 4'b0110; y4 = 4'b0101; in_valid = 1'b1;
    #2;
    check_reg("midcycle");
    in_valid = 1'b0;

    // Asynchronous reset between edges.
    #1;
    rst = 1'b1;
    exp_s = '0; exp_c = '0; exp_v = 1'b0;
    #1;
    check_reg("rst_mid_now");
    in_valid = 1'b1; x4 = 4'hF; y4 = 4'hF;
    @(posedge clk); #1;
    check_reg("rst_mid_edge");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4'b0000, 4'b0001, 1'b1);
    chk("post_rst.S", 32'(s1), 32'd1);
    chk("post_rst.C", 32'(c1), 32'd0);

    // Multi-lane directed pattern.
    step("lanes", 4'b1100, 4'b1010, 1'b1);
    chk("lanes.S", 32'(s4), 32'b0110);
    chk("lanes.C", 32'(c4), 32'b1000);

    // Throughput: eight back-to-back valid random inputs.
    for (int i = 0; i < 8; i++)
      step($sformatf("tput%0d", i), 4'($urandom), 4'($urandom), 1'b1);

    // In-flight input discarded by a reset that covers its edge.
    x4 = 4'b1111; y4 = 4'b1111; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    exp_s = '0; exp_c = '0; exp_v = 1'b0;
    @(posedge clk); #1;
    check_reg("discard_edge");
    @(negedge clk);
    rst = 1'b0;
    step("discard_after", 4'b1111, 4'b1111, 1'b0);

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 12; i++)
      step($sformatf("mix%0d", i), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

    // Combinational instance: settles in the same timestep, no clock needed.
    for (int i = 0; i < 8; i++) begin
      int t;
      xc = 1'(i >> 1); yc = 1'(i); vc = 1'(i >> 2);
      t  = int'(xc) + int'(yc);
      #1;
      chk($sformatf("comb%0d.S", i), 32'(sc), 32'(t % 2));
      chk($sformatf("comb%0d.C", i), 32'(cc), 32'(t / 2));
      chk($sformatf("comb%0d.V", i), 32'(vco), 32'(vc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
